// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with configurable width, modulus and step.
// Free mode wraps modularly with a one-cycle TC pulse; one-shot mode saturates, latches Done and waits for a load.
module counter_updown_mod #(
  parameter int N       = 8,
  parameter int MAX_VAL = 2**N - 1,
  parameter int STEP    = 1
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         Load_en,
  input  logic [N-1:0] Data_in,
  input  logic         En,
  input  logic         Up_dn,
  input  logic         One_shot,
  output logic [N-1:0] Q,
  output logic         TC,
  output logic         Done,
  output logic [0:0]   dbg_state
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  // All arithmetic is one bit wider than Q so a crossing is never lost to overflow.
  localparam logic [N:0] MAX_EXT  = (N+1)'(MAX_VAL);
  localparam logic [N:0] STEP_EXT = (N+1)'(STEP);
  localparam logic [N:0] MOD_EXT  = MAX_EXT + 1'b1;

  logic [0:0]   state;
  logic [N:0]   q_ext;
  logic [N:0]   sum_up;
  logic [N:0]   data_ext;
  logic         crossing;
  logic [N-1:0] next_free;
  logic [N-1:0] next_sat;
  logic [N-1:0] load_val;

  always_comb begin
    q_ext     = {1'b0, Q};
    sum_up    = q_ext + STEP_EXT;
    data_ext  = {1'b0, Data_in};
    crossing  = 1'b0;
    next_free = Q;
    next_sat  = Q;
    load_val  = (data_ext > MAX_EXT) ? MAX_EXT[N-1:0] : Data_in;
    if (Up_dn) begin
      crossing  = (sum_up > MAX_EXT);
      next_free = crossing ? N'(sum_up - MOD_EXT) : sum_up[N-1:0];
      next_sat  = MAX_EXT[N-1:0];
    end else begin
      crossing  = (q_ext < STEP_EXT);
      next_free = crossing ? N'(q_ext + MOD_EXT - STEP_EXT) : N'(q_ext - STEP_EXT);
      next_sat  = '0;
    end
  end

  // Priority: reset > load > enabled count in RUN > hold. TC is low on every non-crossing edge.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      Q     <= '0;
      TC    <= 1'b0;
      Done  <= 1'b0;
      state <= ST_RUN;
    end else if (Load_en) begin
      Q     <= load_val;
      TC    <= 1'b0;
      Done  <= 1'b0;
      state <= ST_RUN;
    end else if (En && (state == ST_RUN)) begin
      TC <= crossing;
      if (crossing && One_shot) begin
        Q     <= next_sat;
        Done  <= 1'b1;
        state <= ST_DONE;
      end else begin
        Q <= next_free;
      end
    end else begin
      TC <= 1'b0;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: default 8-bit, decade (step 1) and decade-step-3 instances share stimulus.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       one_shot = 1'b0;

  logic [7:0] q_def, q_dec, q_stp;
  logic       tc_def, tc_dec, tc_stp;
  logic       done_def, done_dec, done_stp;
  logic [0:0] st_def, st_dec, st_stp;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [0:0] ST_DONE = 1'b1;

  always #5 clk = ~clk;

  counter_updown_mod #(.N(8)) u_def (
    .CLK(clk), .RST_n(rst_n), .Load_en(load_en), .Data_in(data_in), .En(en),
    .Up_dn(up_dn), .One_shot(one_shot), .Q(q_def), .TC(tc_def), .Done(done_def),
    .dbg_state(st_def)
  );

  counter_updown_mod #(.N(8), .MAX_VAL(9), .STEP(1)) u_dec (
    .CLK(clk), .RST_n(rst_n), .Load_en(load_en), .Data_in(data_in), .En(en),
    .Up_dn(up_dn), .One_shot(one_shot), .Q(q_dec), .TC(tc_dec), .Done(done_dec),
    .dbg_state(st_dec)
  );

  counter_updown_mod #(.N(8), .MAX_VAL(9), .STEP(3)) u_stp (
    .CLK(clk), .RST_n(rst_n), .Load_en(load_en), .Data_in(data_in), .En(en),
    .Up_dn(up_dn), .One_shot(one_shot), .Q(q_stp), .TC(tc_stp), .Done(done_stp),
    .dbg_state(st_stp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle away from it before sampling or driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_en = 1'b1;
    data_in = v;
    cyc();
    load_en = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic       exp_tc[$];

    // Reset with En high for two edges
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1;
    cyc(); cyc();
    check("rst_q_def", q_def, 0);
    check("rst_tc_def", tc_def, 0);
    check("rst_done_def", done_def, 0);
    check("rst_q_dec", q_dec, 0);
    check("rst_q_stp", q_stp, 0);

    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_q_def", q_def, 0);
    end

    // Decade wrap, up by 1
    do_load(8'd7);
    check("ld7_q_dec", q_dec, 7);
    exp_q  = '{8'd8, 8'd9, 8'd0, 8'd1};
    exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("dec_up_q", q_dec, exp_q[i]);
      check("dec_up_tc", tc_dec, exp_tc[i]);
    end
    en = 1'b0;

    // Down wrap with step 3
    do_load(8'd4);
    check("ld4_q_stp", q_stp, 4);
    up_dn = 1'b0; en = 1'b1;
    exp_q  = '{8'd1, 8'd8, 8'd5};
    exp_tc = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stp_dn_q", q_stp, exp_q[i]);
      check("stp_dn_tc", tc_stp, exp_tc[i]);
    end
    en = 1'b0; up_dn = 1'b1;

    // One-shot saturation
    do_load(8'd8);
    one_shot = 1'b1; en = 1'b1;
    cyc();
    check("os1_q", q_dec, 9); check("os1_tc", tc_dec, 0); check("os1_done", done_dec, 0);
    cyc();
    check("os2_q", q_dec, 9); check("os2_tc", tc_dec, 1); check("os2_done", done_dec, 1);
    check("os2_state", st_dec, ST_DONE);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("os_hold_q", q_dec, 9); check("os_hold_tc", tc_dec, 0); check("os_hold_done", done_dec, 1);
    end
    one_shot = 1'b0;
    cyc();
    check("os_clr_mode_q", q_dec, 9); check("os_clr_mode_done", done_dec, 1);
    check("os_clr_mode_tc", tc_dec, 0);
    do_load(8'd2);
    check("os_reload_q", q_dec, 2); check("os_reload_done", done_dec, 0);
    cyc();
    check("os_after_q", q_dec, 3);

    // Load beats a simultaneous enable
    load_en = 1'b1; data_in = 8'd5; en = 1'b1;
    cyc();
    check("pri_q", q_dec, 5); check("pri_tc", tc_dec, 0);
    // Out-of-range load clamps, then crosses on the next up-count
    data_in = 8'd200;
    cyc();
    load_en = 1'b0;
    check("clamp_q_dec", q_dec, 9);
    check("noclamp_q_def", q_def, 200);
    cyc();
    check("clamp_cross_q", q_dec, 0); check("clamp_cross_tc", tc_dec, 1);
    en = 1'b0;

    // Full-range wrap on the 8-bit instance
    do_load(8'd255);
    en = 1'b1;
    cyc();
    check("def_wrap_q", q_def, 0); check("def_wrap_tc", tc_def, 1);
    en = 1'b0;

    // Reset while in DONE
    do_load(8'd9);
    one_shot = 1'b1; en = 1'b1;
    cyc();
    check("pre_rst_done", done_dec, 1); check("pre_rst_q", q_dec, 9);
    en = 1'b0; rst_n = 1'b0;
    cyc();
    check("mid_rst_q", q_dec, 0); check("mid_rst_done", done_dec, 0); check("mid_rst_tc", tc_dec, 0);
    rst_n = 1'b1; en = 1'b1;
    cyc();
    check("post_rst_q", q_dec, 1);
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
